hazard_stall_unit: RTL

Decode-stage hazard controller sitting directly upstream of the EX stage and its operand-forwarding logic. It detects load-use hazards that forwarding cannot cover, holds the pipeline while a multi-cycle EX operation (divide/FPU) completes, and flushes on taken branches. It drives the hold/bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. The integer/float register-type matching is identical to the EX forwarding rules.

---
 rtl/hazard_stall_unit_pkg.sv | 27 ++
 rtl/lu_hazard_detect.sv | 41 ++++
 rtl/hazard_stall_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the decode-stage hazard controller: register-type
// decode helpers, hazard FSM encoding and the bubble instruction.
package hazard_stall_unit_pkg;

    localparam logic [1:0]  REG_TYPE_INT  = 2'b00;
    localparam logic [1:0]  REG_TYPE_FLT3 = 2'b11;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    typedef enum logic [0:0] {
        StIdle,
        StMcWait
    } hz_state_e;

    function automatic logic op1_is_flt(input logic [1:0] reg_type);
        return reg_type[1];
    endfunction

    function automatic logic op2_is_flt(input logic [1:0] reg_type);
        return reg_type != REG_TYPE_INT;
    endfunction

    // Only three-source float ops (e.g. fused multiply-add) have a third operand.
    function automatic logic op3_exists(input logic [1:0] reg_type);
        return reg_type == REG_TYPE_FLT3;
    endfunction

endpackage

// File: rtl/lu_hazard_detect.sv
// Combinational load-use comparison of the EX load destination against each used ID
// source operand, with the same int/float file matching as EX forwarding.
module lu_hazard_detect
    import hazard_stall_unit_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_addr_i,
    input  logic       ex_write_en_i,
    input  logic       ex_f_write_en_i,
    input  logic [4:0] id_addr1_i,
    input  logic [4:0] id_addr2_i,
    input  logic [4:0] id_addr3_i,
    input  logic [2:0] id_rs_used_i,
    input  logic [1:0] id_reg_type_i,
    output logic       lu_o
);

    // x0 is hardwired zero, but f0 is a real register.
    function automatic logic src_hit(input logic [4:0] src_addr, input logic is_flt,
                                     input logic [4:0] dst_addr, input logic int_we,
                                     input logic flt_we);
        if (src_addr != dst_addr) return 1'b0;
        if (is_flt) return flt_we;
        return int_we && (dst_addr != 5'd0);
    endfunction

    logic [2:0] hit;

    always_comb begin
        hit[0] = id_rs_used_i[0] &&
                 src_hit(id_addr1_i, op1_is_flt(id_reg_type_i), ex_addr_i,
                         ex_write_en_i, ex_f_write_en_i);
        hit[1] = id_rs_used_i[1] &&
                 src_hit(id_addr2_i, op2_is_flt(id_reg_type_i), ex_addr_i,
                         ex_write_en_i, ex_f_write_en_i);
        hit[2] = id_rs_used_i[2] && op3_exists(id_reg_type_i) &&
                 src_hit(id_addr3_i, 1'b1, ex_addr_i, ex_write_en_i, ex_f_write_en_i);
        lu_o   = ex_mem_read_i && (|hit);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use stall, taken-branch flush and, when
// HAZARD_MULTICYCLE_EN is defined, pipeline hold for multi-cycle EX operations.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned McLatency = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_addr1_i,
    input  logic [4:0] id_addr2_i,
    input  logic [4:0] id_addr3_i,
    input  logic [2:0] id_rs_used_i,
    input  logic [1:0] id_reg_type_i,
    input  logic       id_mc_op_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_addr_i,
    input  logic       ex_write_en_i,
    input  logic       ex_f_write_en_i,
    input  logic       ex_branch_taken_i,
    output logic       pc_hold_o,
    output logic       if_id_hold_o,
    output logic       id_ex_hold_o,
    output logic       id_ex_bubble_o,
    output logic       ex_mem_bubble_o,
    output logic       if_id_flush_o,
    output logic       mc_busy_o
);

    logic lu;

    lu_hazard_detect u_lu_hazard_detect (
        .ex_mem_read_i  (ex_mem_read_i),
        .ex_addr_i      (ex_addr_i),
        .ex_write_en_i  (ex_write_en_i),
        .ex_f_write_en_i(ex_f_write_en_i),
        .id_addr1_i     (id_addr1_i),
        .id_addr2_i     (id_addr2_i),
        .id_addr3_i     (id_addr3_i),
        .id_rs_used_i   (id_rs_used_i),
        .id_reg_type_i  (id_reg_type_i),
        .lu_o           (lu)
    );

`ifdef HAZARD_MULTICYCLE_EN
    localparam int unsigned CntW = $clog2(McLatency) + 1;

    hz_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_hold_o       = 1'b0;
        if_id_hold_o    = 1'b0;
        id_ex_hold_o    = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        if_id_flush_o   = 1'b0;
        mc_busy_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ex_branch_taken_i) begin
                    if_id_flush_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end else if (lu) begin
                    pc_hold_o      = 1'b1;
                    if_id_hold_o   = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end else if (id_mc_op_i && (McLatency > 1)) begin
                    state_d = StMcWait;
                    cnt_d   = CntW'(McLatency - 1);
                end
            end
            StMcWait: begin
                // EX owns the MC op here, so hazards and redirects are not evaluated.
                mc_busy_o = 1'b1;
                if (cnt_q != CntW'(1)) begin
                    pc_hold_o       = 1'b1;
                    if_id_hold_o    = 1'b1;
                    id_ex_hold_o    = 1'b1;
                    ex_mem_bubble_o = 1'b1;
                    cnt_d           = cnt_q - CntW'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst_i) begin
            pc_hold_o       = 1'b0;
            if_id_hold_o    = 1'b0;
            id_ex_hold_o    = 1'b0;
            id_ex_bubble_o  = 1'b0;
            ex_mem_bubble_o = 1'b0;
            if_id_flush_o   = 1'b0;
            mc_busy_o       = 1'b0;
        end
    end
`else
    logic unused_mc_inputs;
    assign unused_mc_inputs = ^{clk_i, id_mc_op_i};

    always_comb begin
        pc_hold_o      = 1'b0;
        if_id_hold_o   = 1'b0;
        id_ex_bubble_o = 1'b0;
        if_id_flush_o  = 1'b0;
        if (!rst_i) begin
            if (ex_branch_taken_i) begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end else if (lu) begin
                pc_hold_o      = 1'b1;
                if_id_hold_o   = 1'b1;
                id_ex_bubble_o = 1'b1;
            end
        end
    end

    assign id_ex_hold_o    = 1'b0;
    assign ex_mem_bubble_o = 1'b0;
    assign mc_busy_o       = 1'b0;
`endif

endmodule
